pio_dribbler_ctrl: RTL



---
 rtl/pio_dribbler_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/pio_dribbler_ctrl.sv
// pio_dribbler_ctrl: Avalon-MM slave PIO for the dribbler control bus.
// Four registers: DATA, SET/STATUS, CLR/COUNT, WDOG. Writes to DATA/SET/CLR
// update out_port one cycle later and refresh the watchdog; if the watchdog
// counts down to zero without a refresh, out_port falls back to SAFE_VALUE.
//
// Build option: define PIO_DRIBBLER_CTRL_WDOG_EN to include the refresh
// watchdog (reload, count, expired). Without it, WDOG/COUNT/STATUS read 0,
// WDOG writes are ignored and out_port only changes through DATA/SET/CLR.
//
// Bus handshake: single-cycle slave with zero wait states. A write is taken
// on the rising edge where chipselect && !write_n; readdata is combinational
// from address and has no side effects.
module pio_dribbler_ctrl #(
   parameter int               WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] SAFE_VALUE  = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   logic             wr_en;
   logic             expire;
   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] data_next;
   logic             unused_bits;

   assign wr_en       = chipselect && !write_n;
   assign unused_bits = &{1'b0, writedata};
   assign out_port    = data_out;

`ifdef PIO_DRIBBLER_CTRL_WDOG_EN
   logic [31:0] reload;
   logic [31:0] count;
   logic        expired;

   // Expiry happens only on the 1 -> 0 step with no write of any kind;
   // DATA/SET/CLR writes reload the count and WDOG writes load it directly.
   assign expire = (count == 32'd1) && !wr_en;

   // Watchdog state: WDOG write loads reload/count, refresh reloads count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reload  <= 32'd0;
         count   <= 32'd0;
         expired <= 1'b0;
      end else begin
         if (wr_en && (address == 2'd3)) begin
            reload  <= writedata;
            count   <= writedata;
            expired <= 1'b0;
         end else if (wr_en) begin
            count <= reload;
         end else if (count != 32'd0) begin
            count <= count - 32'd1;
            if (expire) begin
               expired <= 1'b1;
            end
         end
      end
   end
`else
   assign expire = 1'b0;
`endif

   // Next data_out: bus writes take priority over the watchdog fallback.
   always_comb begin
      data_next = data_out;
      if (wr_en) begin
         case (address)
            2'd0:    data_next = writedata[WIDTH-1:0];
            2'd1:    data_next = data_out | writedata[WIDTH-1:0];
            2'd2:    data_next = data_out & ~writedata[WIDTH-1:0];
            default: data_next = data_out;
         endcase
      end else if (expire) begin
         data_next = SAFE_VALUE;
      end
   end

   // Output register driving the dribbler pins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= RESET_VALUE;
      end else begin
         data_out <= data_next;
      end
   end

   // Combinational read mux, zero wait states.
   always_comb begin
      readdata = 32'd0;
      case (address)
         2'd0: readdata[WIDTH-1:0] = data_out;
`ifdef PIO_DRIBBLER_CTRL_WDOG_EN
         2'd1: readdata[1:0] = {(count != 32'd0), expired};
         2'd2: readdata = count;
         2'd3: readdata = reload;
`endif
         default: readdata = 32'd0;
      endcase
   end

endmodule
